tx: RTL and testbench

TX -- requirements
Module: tx

---
 rtl/tx.sv | 119 +++++++++++
 tb/tb_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tx.sv
// UART-style serial transmitter: start, 8 data bits LSB first, odd parity, stop.
// Four-phase Send/Sent handshake; all outputs come straight from flops.
module tx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       Send,
   input  logic [7:0] Din,
   output logic       Sout,
   output logic       Sent,
   output logic       Busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      ACK   = 3'd5
   } state_t;

   localparam logic [12:0] TMAX = 13'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [12:0] timer_q, timer_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        sout_q, sout_d;
   logic        sent_q, sent_d;
   logic        busy_q, busy_d;
   logic        timer_done, bit_done;

   assign timer_done = (timer_q == TMAX);
   assign bit_done   = (idx_q == 3'd7);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         sout_q  <= 1'b1;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         sout_q  <= sout_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_done ? 13'd0 : timer_q + 13'd1;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (Send) begin
               state_d = START;
               shift_d = Din;
               par_d   = ~^Din;
            end
         end
         START: begin
            if (timer_done) begin
               state_d = BITS;
               idx_d   = '0;
            end
         end
         BITS: begin
            if (timer_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (bit_done) state_d = PAR;
            end
         end
         PAR:  if (timer_done) state_d = STOP;
         STOP: if (timer_done) state_d = ACK;
         ACK: begin
            timer_d = '0;
            if (!Send) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_comb begin
      sout_d = 1'b1;
      case (state_d)
         START:   sout_d = 1'b0;
         BITS:    sout_d = shift_d[0];
         PAR:     sout_d = par_d;
         default: sout_d = 1'b1;
      endcase
      sent_d = (state_d == ACK);
      busy_d = (state_d != IDLE);
   end

   assign Sout = sout_q;
   assign Sent = sent_q;
   assign Busy = busy_q;

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx with CLKS_PER_BIT=16: expected frame bits are queued
// when a byte is sent and popped as the serial line is sampled.
module tb_tx;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Send = 1'b0;
   logic [7:0] Din = 8'h00;
   logic       Sout, Sent, Busy;

   int   n_chk = 0;
   int   n_err = 0;
   logic exp_q[$];

   tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .Reset_n(Reset_n), .Send(Send), .Din(Din),
      .Sout(Sout), .Sent(Sent), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      exp_q.push_back(~^d);
      exp_q.push_back(1'b1);
   endtask

   // Drive a request and return right after the acceptance edge.
   task automatic start(input logic [7:0] d);
      @(negedge clk);
      Send = 1'b1;
      Din  = d;
      push_frame(d);
      @(posedge clk);
   endtask

   // Sample every cycle of the frame, then the handshake tail.
   task automatic capture(input bit hold, input bit chg, input logic [7:0] new_din);
      for (int j = 0; j < 11 * CPB; j++) begin
         @(negedge clk);
         if (j == 0) begin
            chk("busy_rise", Busy, 1);
            if (!hold) Send = 1'b0;
         end
         if (j == 1 && chg) Din = new_din;
         if (exp_q.size() == 0) chk("queue_underrun", exp_q.size(), 1);
         else chk($sformatf("sout_c%0d", j), Sout, exp_q[0]);
         chk("sent_low", Sent, 0);
         if (j % CPB == CPB - 1 && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      chk("sent_rise", Sent, 1);
      chk("busy_ack", Busy, 1);
      chk("sout_ack", Sout, 1);
      if (hold) begin
         repeat (5) @(negedge clk);
         chk("sent_hold", Sent, 1);
         chk("busy_hold", Busy, 1);
         Send = 1'b0;
      end
      @(negedge clk);
      chk("sent_fall", Sent, 0);
      chk("busy_fall", Busy, 0);
      chk("sout_gap", Sout, 1);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #12;
      chk("rst_sout", Sout, 1);
      chk("rst_sent", Sent, 0);
      chk("rst_busy", Busy, 0);
      @(negedge clk);
      Reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_sout", Sout, 1);
      chk("idle_busy", Busy, 0);

      // Single pulse, then back-to-back frames with the minimum gap
      start(8'h55); capture(0, 0, 8'h00);
      start(8'h01); capture(0, 0, 8'h00);
      start(8'h00); capture(0, 0, 8'h00);
      start(8'hFF); capture(0, 0, 8'h00);

      // Send held through the frame
      start(8'hC3); capture(1, 0, 8'h00);

      // Din changes during START must not affect the frame
      start(8'hA5); capture(0, 1, 8'h3C);

      // Reset asserted during data bit 4
      @(negedge clk);
      Send = 1'b1;
      Din  = 8'h96;
      @(posedge clk);
      @(negedge clk);
      Send = 1'b0;
      repeat (5 * CPB + 4) @(negedge clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("midrst_sout", Sout, 1);
      chk("midrst_busy", Busy, 0);
      chk("midrst_sent", Sent, 0);
      @(negedge clk);
      Reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", Busy, 0);
      start(8'h6B); capture(0, 0, 8'h00);

      // Send held through reset starts a frame on the first edge after release
      @(negedge clk);
      Reset_n = 1'b0;
      Send    = 1'b1;
      Din     = 8'h5A;
      push_frame(8'h5A);
      @(negedge clk);
      chk("rst_send_busy", Busy, 0);
      Reset_n = 1'b1;
      @(posedge clk);
      capture(0, 0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
